// File: rtl/crono_irq_gen.sv
// crono_irq_gen: countdown chronometer producing the IRQN alarm request.
// Holds a BCD HH:MM:SS count, decrements it once per TICK_DIV clocks while
// running, and raises IRQN after the count reaches 00:00:00 until acknowledged.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   load, ld_h/ld_m/ld_s - load pulse and BCD time to capture (validated)
//   start, stop          - begin/resume and pause the countdown
//   irq_ack              - clears IRQN and returns to idle
//   hh, mm, ss           - current BCD count
//   running              - high while counting
//   load_err             - one-cycle pulse when a load is rejected
//   IRQN                 - registered alarm request, active high
module crono_irq_gen #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] ld_h,
    input  logic [7:0] ld_m,
    input  logic [7:0] ld_s,
    input  logic       start,
    input  logic       stop,
    input  logic       irq_ack,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       load_err,
    output logic       IRQN
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] pre, pre_nx;
    logic [7:0]       hh_nx, mm_nx, ss_nx;
    logic [7:0]       hh_dec, mm_dec, ss_dec;
    logic             load_err_nx, irq_nx;
    logic             ld_valid, count_zero, tick;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // One-unit BCD decrement of a digit pair; 00 wraps to the given value.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return wrap;
    endfunction

    assign ld_valid   = bcd_ok(ld_h, 8'h23) && bcd_ok(ld_m, 8'h59) && bcd_ok(ld_s, 8'h59);
    assign count_zero = ({hh, mm, ss} == '0);
    assign tick       = (pre == CNT_W'(TICK_DIV - 1));

    // Borrow ripples from seconds into minutes into hours.
    always_comb begin
        ss_dec = bcd_dec(ss, 8'h59);
        mm_dec = (ss == '0) ? bcd_dec(mm, 8'h59) : mm;
        hh_dec = (ss == '0 && mm == '0) ? bcd_dec(hh, 8'h00) : hh;
    end

    always_comb begin
        state_nx    = state;
        pre_nx      = pre;
        hh_nx       = hh;
        mm_nx       = mm;
        ss_nx       = ss;
        load_err_nx = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (load) begin
                    if (ld_valid) begin
                        hh_nx = ld_h;
                        mm_nx = ld_m;
                        ss_nx = ld_s;
                    end else begin
                        load_err_nx = 1'b1;
                    end
                end else if (start && !count_zero) begin
                    state_nx = RUN;
                    pre_nx   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = PAUSE;
                end else if (tick) begin
                    pre_nx = '0;
                    hh_nx  = hh_dec;
                    mm_nx  = mm_dec;
                    ss_nx  = ss_dec;
                    if ({hh_dec, mm_dec, ss_dec} == '0)
                        state_nx = EXPIRED;
                end else begin
                    pre_nx = pre + CNT_W'(1);
                end
            end
            EXPIRED: begin
                if (irq_ack) begin
                    state_nx = IDLE;
                end else if (load) begin
                    if (ld_valid) begin
                        hh_nx = ld_h;
                        mm_nx = ld_m;
                        ss_nx = ld_s;
                    end else begin
                        load_err_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // IRQN follows the EXPIRED state with one cycle of delay.
        irq_nx = (state == EXPIRED) && !irq_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pre      <= '0;
            hh       <= '0;
            mm       <= '0;
            ss       <= '0;
            running  <= 1'b0;
            load_err <= 1'b0;
            IRQN     <= 1'b0;
        end else begin
            state    <= state_nx;
            pre      <= pre_nx;
            hh       <= hh_nx;
            mm       <= mm_nx;
            ss       <= ss_nx;
            running  <= (state_nx == RUN);
            load_err <= load_err_nx;
            IRQN     <= irq_nx;
        end
    end

endmodule

// File: tb/tb_crono_irq_gen.sv
module tb_crono_irq_gen;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0, irq_ack = 1'b0;
    logic [7:0] ld_h = '0, ld_m = '0, ld_s = '0;
    logic [7:0] hh, mm, ss;
    logic       running, load_err, IRQN;

    crono_irq_gen #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .load(load), .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
        .start(start), .stop(stop), .irq_ack(irq_ack), .hh(hh), .mm(mm), .ss(ss),
        .running(running), .load_err(load_err), .IRQN(IRQN)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
    typedef struct {
        logic [7:0] h, m, s;
        logic       run, err, irq;
    } exp_t;

    exp_t    q[$];
    int      checks = 0, failures = 0;
    mstate_t m_state = M_IDLE;
    int      m_secs = 0, m_pre = 0;
    bit      m_err = 0, m_irq = 0, was_exp;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit field_ok(input logic [7:0] v, input int max);
        int hi, lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        return hi <= 9 && lo <= 9 && (hi * 10 + lo) <= max;
    endfunction

    // Reference model: count kept as plain seconds.
    task automatic model_load();
        if (field_ok(ld_h, 23) && field_ok(ld_m, 59) && field_ok(ld_s, 59))
            m_secs = int'(ld_h[7:4]) * 36000 + int'(ld_h[3:0]) * 3600
                   + int'(ld_m[7:4]) * 600 + int'(ld_m[3:0]) * 60
                   + int'(ld_s[7:4]) * 10 + int'(ld_s[3:0]);
        else
            m_err = 1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_state = M_IDLE; m_secs = 0; m_pre = 0; m_err = 0; m_irq = 0;
        end else begin
            was_exp = (m_state == M_EXP);
            m_err = 0;
            case (m_state)
                M_IDLE, M_PAUSE: begin
                    if (load) model_load();
                    else if (start && m_secs != 0) begin m_state = M_RUN; m_pre = 0; end
                end
                M_RUN: begin
                    if (stop) m_state = M_PAUSE;
                    else if (m_pre == TD - 1) begin
                        m_pre = 0;
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_state = M_EXP;
                    end else m_pre = m_pre + 1;
                end
                M_EXP: begin
                    if (irq_ack) m_state = M_IDLE;
                    else if (load) model_load();
                end
            endcase
            m_irq = was_exp && !irq_ack;
        end
        e.h = to_bcd(m_secs / 3600);
        e.m = to_bcd((m_secs / 60) % 60);
        e.s = to_bcd(m_secs % 60);
        e.run = (m_state == M_RUN);
        e.err = m_err;
        e.irq = m_irq;
        q.push_back(e);
    end

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hh", hh, e.h);
            chk("mm", mm, e.m);
            chk("ss", ss, e.s);
            chk("running", {7'd0, running}, {7'd0, e.run});
            chk("load_err", {7'd0, load_err}, {7'd0, e.err});
            chk("IRQN", {7'd0, IRQN}, {7'd0, e.irq});
        end
    end

    task automatic cyc(input logic r, input logic l, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic st, input logic sp, input logic ak);
        reset = r; load = l; ld_h = h; ld_m = m; ld_s = s; start = st; stop = sp; irq_ack = ak;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    endtask

    task automatic ld(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cyc(0, 1, h, m, s, 0, 0, 0);
    endtask

    task automatic go();    cyc(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0); endtask
    task automatic halt();  cyc(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0); endtask
    task automatic ack();   cyc(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); endtask
    task automatic rst();   cyc(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0); endtask

    initial begin
        int sel, v;
        logic [7:0] rh, rm, rs;
        rst(); rst();
        // countdown to expiry, hold, acknowledge
        ld(8'h00, 8'h00, 8'h02); go(); idle(30); ack(); idle(3);
        // borrow chains
        ld(8'h01, 8'h00, 8'h00); go(); idle(5); halt(); idle(2);
        ld(8'h10, 8'h00, 8'h00); go(); idle(5); halt(); idle(2);
        // pause and resume
        rst(); ld(8'h00, 8'h00, 8'h05); go(); idle(5); halt(); idle(50); go(); idle(6); halt();
        // invalid and boundary loads
        rst();
        ld(8'h00, 8'h60, 8'h00); idle(1);
        ld(8'h24, 8'h00, 8'h00); idle(1);
        ld(8'h00, 8'h00, 8'h1A); idle(1);
        ld(8'h23, 8'h59, 8'h59); idle(2);
        // edge commands
        rst(); go(); idle(2);
        ld(8'h00, 8'h00, 8'h03); go(); idle(2);
        ld(8'h00, 8'h00, 8'h09); idle(1);
        cyc(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0); idle(3);
        // reset while running and while expired
        rst(); ld(8'h00, 8'h03, 8'h07); go(); idle(6); rst(); idle(2);
        ld(8'h00, 8'h00, 8'h01); go(); idle(10); rst(); idle(2);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                v = $urandom_range(0, 4);
                rh = 8'h00; rm = 8'h00; rs = to_bcd(v);
            end else if (sel < 8) begin
                rh = to_bcd($urandom_range(0, 23));
                rm = to_bcd($urandom_range(0, 59));
                rs = to_bcd($urandom_range(0, 59));
            end else if (sel == 8) begin
                rh = ($urandom_range(0, 1) == 1) ? 8'h10 : 8'h01;
                rm = 8'h00; rs = 8'h00;
            end else begin
                rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom);
            end
            cyc($urandom_range(0, 999) < 8, $urandom_range(0, 99) < 6, rh, rm, rs,
                $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 6);
        end
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
